// File: rtl/ssd_frame_decoder_if.sv
// Seven-segment loop-back bus: scanned AN/SEG in, decoded frame out.
// master drives the scan, slave is the decoder.
interface ssd_frame_decoder_if #(
    parameter int BIN_W = 14
);
    logic [3:0]       AN;
    logic [6:0]       SEG;
    logic [15:0]      BCD;
    logic [BIN_W-1:0] BIN;
    logic             VALID;
    logic             ERR;
    logic             LOCK;

    modport master (
        output AN, SEG,
        input  BCD, BIN, VALID, ERR, LOCK
    );

    modport slave (
        input  AN, SEG,
        output BCD, BIN, VALID, ERR, LOCK
    );
endinterface

// File: rtl/ssd_frame_decoder.sv
// Seven-segment scan receiver: locks onto the ones..thousands scan,
// rebuilds the 4-digit frame and converts it to binary.
module ssd_frame_decoder #(
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter int BIN_W       = 14
) (
    input logic               DCLK,
    input logic               RST,
    ssd_frame_decoder_if.slave bus
);

    typedef enum logic {HUNT, COLLECT} col_t;
    typedef enum logic {IDLE, CONV} cnv_t;

    logic [6:0] seg_n;
    logic       seg_ok;
    logic [3:0] seg_dig;
    logic       an_ok;
    logic [1:0] an_idx;

    col_t            col_q, col_d;
    logic [1:0]      exp_q, exp_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            col_err;
    logic            frame_done;
    logic [3:0][3:0] snap_new;

    cnv_t             cnv_q, cnv_d;
    logic [1:0]       step_q, step_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic [BIN_W-1:0] acc_q, acc_d;
    logic [BIN_W-1:0] acc_next;
    logic [3:0]       cur_dig;
    logic [15:0]      bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    assign seg_n = SEG_ACT_LOW ? bus.SEG : ~bus.SEG;

    // Cathode pattern to BCD digit; anything else is illegal.
    always_comb begin
        seg_ok  = 1'b1;
        seg_dig = 4'd0;
        unique case (seg_n)
            7'b1000000: seg_dig = 4'd0;
            7'b1111001: seg_dig = 4'd1;
            7'b0100100: seg_dig = 4'd2;
            7'b0110000: seg_dig = 4'd3;
            7'b0011001: seg_dig = 4'd4;
            7'b0010010: seg_dig = 4'd5;
            7'b0000010: seg_dig = 4'd6;
            7'b1111000: seg_dig = 4'd7;
            7'b0000000: seg_dig = 4'd8;
            7'b0010000: seg_dig = 4'd9;
            default:    seg_ok  = 1'b0;
        endcase
    end

    // One-hot-low anode code to digit position.
    always_comb begin
        an_ok  = 1'b1;
        an_idx = 2'd0;
        unique case (bus.AN)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_ok  = 1'b0;
        endcase
    end

    // Collector next state: follow the scan order, flag breaks in it.
    always_comb begin
        col_d      = col_q;
        exp_d      = exp_q;
        dig_d      = dig_q;
        col_err    = 1'b0;
        frame_done = 1'b0;
        case (col_q)
            HUNT: begin
                if (an_ok && seg_ok && an_idx == 2'd0) begin
                    dig_d    = '0;
                    dig_d[0] = seg_dig;
                    exp_d    = 2'd1;
                    col_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (an_ok && seg_ok && an_idx == exp_q) begin
                    dig_d[an_idx] = seg_dig;
                    exp_d         = exp_q + 2'd1;
                    frame_done    = (an_idx == 2'd3);
                end else if (an_ok && seg_ok && an_idx == 2'd0) begin
                    col_err  = 1'b1;
                    dig_d    = '0;
                    dig_d[0] = seg_dig;
                    exp_d    = 2'd1;
                end else begin
                    col_err = 1'b1;
                    dig_d   = '0;
                    exp_d   = 2'd0;
                    col_d   = HUNT;
                end
            end
            default: col_d = HUNT;
        endcase
    end

    // The thousands digit is still on the bus when the frame completes.
    assign snap_new = {seg_dig, dig_q[2], dig_q[1], dig_q[0]};

    // Thousands first, ones last; x10 as shift-and-add.
    assign cur_dig  = snap_q[2'd3 - step_q];
    assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_dig);

    // Converter next state: four accumulate steps, then publish.
    always_comb begin
        cnv_d   = cnv_q;
        step_d  = step_q;
        snap_d  = snap_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        err_d   = col_err;
        if (cnv_q == CONV) begin
            acc_d  = acc_next;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
                bcd_d   = snap_q;
                bin_d   = acc_next;
                valid_d = 1'b1;
                cnv_d   = IDLE;
            end
        end
        if (frame_done) begin
            if (cnv_q == CONV && step_q != 2'd3) begin
                err_d = 1'b1;
            end
            snap_d = snap_new;
            acc_d  = '0;
            step_d = 2'd0;
            cnv_d  = CONV;
        end
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge DCLK) begin
        if (RST) begin
            col_q   <= HUNT;
            exp_q   <= 2'd0;
            dig_q   <= '0;
            cnv_q   <= IDLE;
            step_q  <= 2'd0;
            snap_q  <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            exp_q   <= exp_d;
            dig_q   <= dig_d;
            cnv_q   <= cnv_d;
            step_q  <= step_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.BCD   = bcd_q;
    assign bus.BIN   = bin_q;
    assign bus.VALID = valid_q;
    assign bus.ERR   = err_q;
    assign bus.LOCK  = (col_q == COLLECT);

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Bench for ssd_frame_decoder: directed scans plus random frames and
// noise, checked every edge against a frame-level reference model.
module tb_ssd_frame_decoder;

    logic DCLK = 1'b0;
    logic RST  = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    ssd_frame_decoder_if #(.BIN_W(14)) bus ();

    ssd_frame_decoder #(
        .SEG_ACT_LOW(1'b1),
        .BIN_W      (14)
    ) dut (
        .DCLK(DCLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 DCLK = ~DCLK;

    logic [6:0] segtab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    logic [3:0] antab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    bit          m_lock;
    int          m_exp;
    int          m_part [4];
    bit          m_pend;
    int          m_due;
    int          m_val;
    logic [15:0] m_pbcd;
    logic [15:0] m_bcd;
    int          m_bin;
    bit          e_valid;
    bit          e_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    // Frame-level model of one scan sample and the result it schedules.
    task automatic model_edge(input bit rst, input logic [3:0] an,
                              input logic [6:0] seg);
        int idx;
        int d;
        bit done;
        int dv;
        logic [15:0] db;
        e_valid = 0;
        e_err   = 0;
        done    = 0;
        dv      = 0;
        db      = '0;
        if (rst) begin
            m_lock = 0;
            m_exp  = 0;
            m_part = '{0, 0, 0, 0};
            m_pend = 0;
            m_bcd  = '0;
            m_bin  = 0;
            return;
        end
        idx = -1;
        for (int i = 0; i < 4; i++) if (an == antab[i]) idx = i;
        d = -1;
        for (int i = 0; i < 10; i++) if (seg == segtab[i]) d = i;
        if (!m_lock) begin
            if (idx == 0 && d >= 0) begin
                m_lock = 1;
                m_part = '{d, 0, 0, 0};
                m_exp  = 1;
            end
        end else if (idx >= 0 && d >= 0 && idx == m_exp) begin
            m_part[idx] = d;
            m_exp = (m_exp + 1) % 4;
            if (idx == 3) begin
                done = 1;
                dv = m_part[3] * 1000 + m_part[2] * 100
                   + m_part[1] * 10 + m_part[0];
                db = {4'(m_part[3]), 4'(m_part[2]),
                      4'(m_part[1]), 4'(m_part[0])};
            end
        end else if (idx == 0 && d >= 0) begin
            e_err  = 1;
            m_part = '{d, 0, 0, 0};
            m_exp  = 1;
        end else begin
            e_err  = 1;
            m_lock = 0;
            m_part = '{0, 0, 0, 0};
            m_exp  = 0;
        end
        if (m_pend && cyc == m_due) begin
            e_valid = 1;
            m_bin   = m_val;
            m_bcd   = m_pbcd;
            m_pend  = 0;
        end
        if (done) begin
            if (m_pend) e_err = 1;
            m_pend = 1;
            m_due  = cyc + 4;
            m_val  = dv;
            m_pbcd = db;
        end
    endtask

    task automatic step(input bit rst, input logic [3:0] an,
                        input logic [6:0] seg);
        RST     = rst;
        bus.AN  = an;
        bus.SEG = seg;
        @(posedge DCLK);
        cyc++;
        model_edge(rst, an, seg);
        #1;
        chk("valid", 32'(bus.VALID), 32'(e_valid));
        chk("err",   32'(bus.ERR),   32'(e_err));
        chk("lock",  32'(bus.LOCK),  32'(m_lock));
        chk("bin",   32'(bus.BIN),   32'(m_bin));
        chk("bcd",   32'(bus.BCD),   32'(m_bcd));
    endtask

    task automatic scan(input int v);
        int dg [4];
        dg[0] = v % 10;
        dg[1] = (v / 10) % 10;
        dg[2] = (v / 100) % 10;
        dg[3] = (v / 1000) % 10;
        for (int i = 0; i < 4; i++) step(0, antab[i], segtab[dg[i]]);
    endtask

    initial begin
        int v;
        int dg;
        int r;
        bus.AN  = 4'b1111;
        bus.SEG = 7'b1111111;
        // Reset state
        step(1, 4'b1111, 7'b1111111);
        step(1, 4'b1111, 7'b1111111);
        // 1234, result appears four edges after thousands
        scan(1234);
        scan(1234);
        // 9999 then 0000
        scan(9999);
        scan(0);
        scan(0);
        // Blank tens digit while locked, then a clean 0042
        step(0, antab[0], segtab[7]);
        step(0, antab[1], 7'b1111111);
        scan(42);
        scan(42);
        // Join mid-frame: no error until locked
        step(0, antab[2], segtab[3]);
        step(0, antab[3], segtab[5]);
        step(0, 4'b0000, segtab[5]);
        step(0, 4'b1111, 7'b1111111);
        scan(8080);
        scan(8080);
        // Continuous 0567 then 0568
        scan(567);
        scan(568);
        scan(568);
        // Ones restart while expecting hundreds
        step(0, antab[0], segtab[1]);
        step(0, antab[1], segtab[2]);
        scan(3141);
        scan(3141);
        // Reset at E2 of conversion for 0321
        scan(321);
        step(0, antab[0], segtab[1]);
        step(1, antab[1], segtab[2]);
        step(1, 4'b1111, 7'b1111111);
        step(0, 4'b1111, 7'b1111111);
        step(0, 4'b1111, 7'b1111111);
        // Random frames with occasional glitches
        for (int f = 0; f < 40; f++) begin
            v = int'($urandom_range(0, 9999));
            for (int i = 0; i < 4; i++) begin
                dg = (i == 0) ? v % 10 : (i == 1) ? (v / 10) % 10 :
                     (i == 2) ? (v / 100) % 10 : (v / 1000) % 10;
                if ($urandom_range(0, 15) == 0)
                    step(0, 4'($urandom), 7'($urandom));
                else
                    step(0, antab[i], segtab[dg]);
            end
        end
        // Random noise mixing legal and illegal samples
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)
                step(0, antab[$urandom_range(0, 3)],
                     segtab[$urandom_range(0, 9)]);
            else
                step(0, 4'($urandom), 7'($urandom));
        end
        // Recover and finish with clean traffic
        step(0, 4'b1111, 7'b1111111);
        scan(7305);
        scan(9999);
        scan(9999);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
